csr_access_ctrl: RTL and testbench
==================================

Name: csr_access_ctrl

Overview:
Sequencer in front of the single-read/single-write-port CSR register file (async read, negedge write). It executes Zicsr read-modify-write instructions, trap entry and MRET as multi-cycle sequences. It arbitrates the one write port between these three requesters and returns the old CSR value or a redirect PC to the core. The core stalls on busy.

Parameters:
MSTATUS_ADDR, 12'h300, mstatus address
MTVEC_ADDR, 12'h305, mtvec address
MEPC_ADDR, 12'h341, mepc address
MCAUSE_ADDR, 12'h342, mcause address

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
csr_req_valid  in  1  CSR instruction request
csr_funct3  in  3  Zicsr funct3
csr_addr  in  12  target CSR
csr_src  in  32  rs1 value
csr_zimm  in  5  immediate operand
trap_req  in  1  trap entry request
trap_cause  in  32  mcause value
trap_pc  in  32  faulting PC
mret_req  in  1  MRET request
req_ready  out  1  IDLE, request accepted this cycle
busy  out  1  sequence in progress
csr_done  out  1  one-cycle pulse: CSR instruction finished
csr_result  out  32  old CSR value, valid with csr_done
csr_illegal  out  1  with csr_done: funct3 000/100, nothing written
redirect_valid  out  1  one-cycle pulse: PC redirect
redirect_pc  out  32  new PC, valid with redirect_valid
csr_rd_addr  out  12  to CSR file read address
csr_rd_data  in  32  from CSR file read data
csr_write_en  out  1  to CSR file write enable
csr_wb_addr  out  12  to CSR file write address
csr_wb_data  out  32  to CSR file write data

Behaviour:
- Synchronous, active-high reset on the clk posedge. Reset forces: state IDLE, all latches 0, all outputs 0, req_ready=1. Reset mid-sequence aborts it, and no write is issued after reset.
- Timing of outputs:
  - The CSR-file-side outputs are combinational decodes of the registered state and latches.
  - csr_done, csr_result, csr_illegal, redirect_* and busy are registered.
  - The file writes on negedge, so any read value is latched at a posedge before its write cycle.
- Acceptance: only in IDLE. Priority is trap_req > mret_req > csr_req_valid. Lower-priority requests are not consumed and must be held by the requester. Requests arriving while busy are ignored.
- CSR instruction (accepted at cycle N):
  - N+1 (C_READ): rd_addr = csr_addr; old value latched.
  - N+2 (C_WRITE): write per op, using the latched old value and operand (funct3[2] ? zero-extended zimm : csr_src):
    - RW: new = operand.
    - RS: new = old | operand.
    - RC: new = old & ~operand.
    - RS/RC with operand == 0: csr_write_en = 0.
    - RW always writes.
  - Done pulse and result are registered into cycle N+3. State is back to IDLE, so req_ready=1 at N+3.
  - Illegal funct3: C_READ, then C_WRITE with no write; csr_illegal=1 with done; csr_result=0.
- Trap (accepted at N):
  - T_EPC: write mepc = trap_pc & ~3.
  - T_CAUSE: write mcause = trap_cause.
  - T_ST_RD: latch mstatus.
  - T_ST_WR: write mstatus with MPIE[7] = old MIE[3], MIE = 0, MPP[12:11] = 2'b11, other bits unchanged.
  - T_VEC: read mtvec; redirect_pc = mtvec & ~3 registered; redirect_valid pulses at N+6; IDLE at N+6.
- MRET (accepted at N):
  - M_ST_RD: latch mstatus.
  - M_ST_WR: MIE = old MPIE, MPIE = 1, MPP = 2'b11.
  - M_EPC: read mepc; redirect_pc = mepc & ~3; pulse at N+4.
- busy = 1 from the cycle after acceptance until the final state; 0 in the cycle the pulse appears.
- Exactly one write per cycle; csr_write_en = 0 in every read or idle state; csr_wb_addr = 0 when not writing.

Optional Feature:
Macro VECTORED_MTVEC_EN.
- Defined: in T_VEC, if mtvec[1:0] == 2'b01 and trap_cause[31] == 1, redirect_pc = (mtvec & ~3) + (trap_cause[30:0] << 2), truncated to 32 bits. All other mtvec modes and causes use the base address.
- Undefined: mtvec[1:0] is ignored; the base address is always used.

Test Plan:
- Reset, then: mtvec=0x80, mstatus=0x8. Trap with cause=2, pc=0x1002 -> mepc=0x1000, mcause=2, mstatus=0x1880, redirect_pc=0x80 pulsed at N+6.
- CSRRS addr 0x340: old 0x0F, csr_src 0xF0 -> write 0xFF at N+2, csr_result=0x0F with done at N+3. CSRRC same addr, zimm 0x3 (funct3 111) -> value 0xFC.
- CSRRS with csr_src=0 -> no csr_write_en at any cycle, csr_result = current value. funct3 100 -> csr_illegal=1, no write.
- Simultaneous trap_req, mret_req and csr_req_valid in IDLE -> trap sequence runs, req_ready=0 until pulse. Then MRET with mepc=0x1000, mstatus=0x1880 -> mstatus=0x1888, redirect_pc=0x1000.
- rst asserted during T_ST_WR -> no further writes, all outputs 0 next cycle, req_ready=1.
- VECTORED_MTVEC_EN defined, mtvec=0x101, cause=0x80000007 -> redirect_pc=0x11C. With the macro undefined -> 0x100.

Source files
------------

// File: rtl/csr_access_ctrl_if.sv
// Core/CSR-file bundle seen by csr_access_ctrl: request side, response side and CSR file port.
// The controller uses the slave modport; the core plus CSR file side uses the master modport.
interface csr_access_ctrl_if;
  logic        csr_req_valid;
  logic [2:0]  csr_funct3;
  logic [11:0] csr_addr;
  logic [31:0] csr_src;
  logic [4:0]  csr_zimm;
  logic        trap_req;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic        mret_req;
  logic        req_ready;
  logic        busy;
  logic        csr_done;
  logic [31:0] csr_result;
  logic        csr_illegal;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [11:0] csr_rd_addr;
  logic [31:0] csr_rd_data;
  logic        csr_write_en;
  logic [11:0] csr_wb_addr;
  logic [31:0] csr_wb_data;

  modport slave (
    input  csr_req_valid, csr_funct3, csr_addr, csr_src, csr_zimm,
    input  trap_req, trap_cause, trap_pc, mret_req, csr_rd_data,
    output req_ready, busy, csr_done, csr_result, csr_illegal,
    output redirect_valid, redirect_pc, csr_rd_addr, csr_write_en, csr_wb_addr, csr_wb_data
  );

  modport master (
    output csr_req_valid, csr_funct3, csr_addr, csr_src, csr_zimm,
    output trap_req, trap_cause, trap_pc, mret_req, csr_rd_data,
    input  req_ready, busy, csr_done, csr_result, csr_illegal,
    input  redirect_valid, redirect_pc, csr_rd_addr, csr_write_en, csr_wb_addr, csr_wb_data
  );
endinterface

// File: rtl/csr_access_ctrl.sv
// Sequences Zicsr read-modify-write, trap entry and MRET onto a single-port CSR file.
// Define VECTORED_MTVEC_EN to honour vectored mtvec mode for interrupt causes.
module csr_access_ctrl #(
  parameter logic [11:0] MSTATUS_ADDR = 12'h300,
  parameter logic [11:0] MTVEC_ADDR   = 12'h305,
  parameter logic [11:0] MEPC_ADDR    = 12'h341,
  parameter logic [11:0] MCAUSE_ADDR  = 12'h342
) (
  input logic              clk,
  input logic              rst,
  csr_access_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    StIdle, StCRead, StCWrite,
    StTEpc, StTCause, StTStRd, StTStWr, StTVec,
    StMStRd, StMStWr, StMEpc
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [11:0] addr_q, addr_d;
  logic [31:0] operand_q, operand_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] old_q, old_d;

  logic        done_q, done_d;
  logic [31:0] result_q, result_d;
  logic        illegal_q, illegal_d;
  logic        redir_valid_q, redir_valid_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic        busy_q, busy_d;

  logic        we;
  logic [11:0] wb_addr;
  logic [31:0] wb_data;
  logic [11:0] rd_addr;
  logic [31:0] mtvec_base;

  assign mtvec_base = bus.csr_rd_data & ~32'h3;

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    operand_d     = operand_q;
    pc_d          = pc_q;
    cause_d       = cause_q;
    old_d         = old_q;
    done_d        = 1'b0;
    result_d      = 32'h0;
    illegal_d     = 1'b0;
    redir_valid_d = 1'b0;
    redir_pc_d    = 32'h0;
    we            = 1'b0;
    wb_addr       = 12'h0;
    wb_data       = 32'h0;
    rd_addr       = 12'h0;

    case (state_q)
      StIdle: begin
        if (bus.trap_req) begin
          pc_d    = bus.trap_pc;
          cause_d = bus.trap_cause;
          state_d = StTEpc;
        end else if (bus.mret_req) begin
          state_d = StMStRd;
        end else if (bus.csr_req_valid) begin
          op_d      = bus.csr_funct3[1:0];
          addr_d    = bus.csr_addr;
          operand_d = bus.csr_funct3[2] ? {27'h0, bus.csr_zimm} : bus.csr_src;
          state_d   = StCRead;
        end
      end
      StCRead: begin
        rd_addr = addr_q;
        old_d   = bus.csr_rd_data;
        state_d = StCWrite;
      end
      StCWrite: begin
        // op 00 is the illegal funct3 pair 000/100: finish without touching the file
        case (op_q)
          2'b01: begin
            we      = 1'b1;
            wb_data = operand_q;
          end
          2'b10: begin
            we      = (operand_q != 32'h0);
            wb_data = old_q | operand_q;
          end
          2'b11: begin
            we      = (operand_q != 32'h0);
            wb_data = old_q & ~operand_q;
          end
          default: ;
        endcase
        if (we) begin
          wb_addr = addr_q;
        end else begin
          wb_data = 32'h0;
        end
        done_d    = 1'b1;
        illegal_d = (op_q == 2'b00);
        result_d  = (op_q == 2'b00) ? 32'h0 : old_q;
        state_d   = StIdle;
      end
      StTEpc: begin
        we      = 1'b1;
        wb_addr = MEPC_ADDR;
        wb_data = pc_q & ~32'h3;
        state_d = StTCause;
      end
      StTCause: begin
        we      = 1'b1;
        wb_addr = MCAUSE_ADDR;
        wb_data = cause_q;
        state_d = StTStRd;
      end
      StTStRd: begin
        rd_addr = MSTATUS_ADDR;
        old_d   = bus.csr_rd_data;
        state_d = StTStWr;
      end
      StTStWr: begin
        // MPIE <= MIE, MIE <= 0, MPP <= M
        we             = 1'b1;
        wb_addr        = MSTATUS_ADDR;
        wb_data        = old_q;
        wb_data[7]     = old_q[3];
        wb_data[3]     = 1'b0;
        wb_data[12:11] = 2'b11;
        state_d        = StTVec;
      end
      StTVec: begin
        rd_addr       = MTVEC_ADDR;
        redir_valid_d = 1'b1;
        redir_pc_d    = mtvec_base;
`ifdef VECTORED_MTVEC_EN
        if (bus.csr_rd_data[1:0] == 2'b01 && cause_q[31]) begin
          redir_pc_d = mtvec_base + {cause_q[29:0], 2'b00};
        end
`endif
        state_d = StIdle;
      end
      StMStRd: begin
        rd_addr = MSTATUS_ADDR;
        old_d   = bus.csr_rd_data;
        state_d = StMStWr;
      end
      StMStWr: begin
        we             = 1'b1;
        wb_addr        = MSTATUS_ADDR;
        wb_data        = old_q;
        wb_data[3]     = old_q[7];
        wb_data[7]     = 1'b1;
        wb_data[12:11] = 2'b11;
        state_d        = StMEpc;
      end
      StMEpc: begin
        rd_addr       = MEPC_ADDR;
        redir_valid_d = 1'b1;
        redir_pc_d    = bus.csr_rd_data & ~32'h3;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      op_q          <= 2'b00;
      addr_q        <= 12'h0;
      operand_q     <= 32'h0;
      pc_q          <= 32'h0;
      cause_q       <= 32'h0;
      old_q         <= 32'h0;
      done_q        <= 1'b0;
      result_q      <= 32'h0;
      illegal_q     <= 1'b0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= 32'h0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      operand_q     <= operand_d;
      pc_q          <= pc_d;
      cause_q       <= cause_d;
      old_q         <= old_d;
      done_q        <= done_d;
      result_q      <= result_d;
      illegal_q     <= illegal_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.req_ready      = (state_q == StIdle);
  assign bus.busy           = busy_q;
  assign bus.csr_done       = done_q;
  assign bus.csr_result     = result_q;
  assign bus.csr_illegal    = illegal_q;
  assign bus.redirect_valid = redir_valid_q;
  assign bus.redirect_pc    = redir_pc_q;
  assign bus.csr_rd_addr    = rd_addr;
  assign bus.csr_write_en   = we;
  assign bus.csr_wb_addr    = wb_addr;
  assign bus.csr_wb_data    = wb_data;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Self-checking bench for csr_access_ctrl: behavioural CSR file plus reference rules for
// Zicsr ops, trap entry and MRET, with directed and $urandom stimulus.
module tb_csr_access_ctrl;
  localparam logic [11:0] MSTATUS = 12'h300;
  localparam logic [11:0] MTVEC   = 12'h305;
  localparam logic [11:0] MEPC    = 12'h341;
  localparam logic [11:0] MCAUSE  = 12'h342;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  csr_access_ctrl_if bus ();

  csr_access_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // CSR file: asynchronous read, negedge write; poke port preloads state while idle
  typedef struct packed {
    logic [11:0] a;
    logic [31:0] d;
  } wr_t;

  logic [31:0] regs [4096];
  wr_t         wr_q [$];
  logic        poke_en;
  logic [11:0] poke_a;
  logic [31:0] poke_d;

  assign bus.csr_rd_data = regs[bus.csr_rd_addr];

  always @(negedge clk) begin
    if (bus.csr_write_en) begin
      regs[bus.csr_wb_addr] <= bus.csr_wb_data;
      wr_q.push_back({bus.csr_wb_addr, bus.csr_wb_data});
    end else if (poke_en) begin
      regs[poke_a] <= poke_d;
    end
  end

  int errors = 0;
  int checks = 0;

  // Reference rules
  function automatic logic [31:0] trap_status(input logic [31:0] s);
    logic [31:0] r;
    r = (s & ~32'h0000_1888) | 32'h0000_1800;
    if (s[3]) r = r | 32'h80;
    return r;
  endfunction

  function automatic logic [31:0] mret_status(input logic [31:0] s);
    logic [31:0] r;
    r = (s & ~32'h0000_1888) | 32'h0000_1880;
    if (s[7]) r = r | 32'h8;
    return r;
  endfunction

  function automatic logic [31:0] trap_target(input logic [31:0] mtvec, input logic [31:0] cause);
    logic [31:0] r;
    r = mtvec & ~32'h3;
`ifdef VECTORED_MTVEC_EN
    if (mtvec[1:0] == 2'b01 && cause[31]) r = r + ((cause & 32'h7FFF_FFFF) << 2);
`else
    if (cause == 32'hFFFF_FFFF && mtvec == 32'h0) r = 32'h0;
`endif
    return r;
  endfunction

  task automatic clear_inputs();
    bus.csr_req_valid = 1'b0;
    bus.csr_funct3    = 3'b000;
    bus.csr_addr      = 12'h0;
    bus.csr_src       = 32'h0;
    bus.csr_zimm      = 5'h0;
    bus.trap_req      = 1'b0;
    bus.trap_cause    = 32'h0;
    bus.trap_pc       = 32'h0;
    bus.mret_req      = 1'b0;
  endtask

  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    poke_en = 1'b1;
    poke_a  = a;
    poke_d  = d;
    @(negedge clk);
    #1 poke_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.csr_done, bus.busy, bus.redirect_valid, bus.csr_illegal, bus.csr_write_en} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got done/busy/rv/ill/we=%b want 00000",
               {bus.csr_done, bus.busy, bus.redirect_valid, bus.csr_illegal, bus.csr_write_en});
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", bus.req_ready);
    end
    checks++;
    if ({bus.csr_result, bus.redirect_pc, bus.csr_wb_data} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h want 0", bus.csr_result, bus.redirect_pc,
               bus.csr_wb_data);
    end
    checks++;
    if ({bus.csr_rd_addr, bus.csr_wb_addr} !== 24'h0) begin
      errors++;
      $display("FAIL reset_addr: got rd %h wb %h want 0", bus.csr_rd_addr, bus.csr_wb_addr);
    end
  endtask

  task automatic test_csr(input logic [2:0] f3, input logic [11:0] addr, input logic [31:0] old,
                          input logic [31:0] src, input logic [4:0] zimm);
    logic [31:0] op, newv, expv;
    logic        exp_we, ill;
    int          lat, base;
    ill    = (f3 == 3'b000 || f3 == 3'b100);
    op     = f3[2] ? 32'(zimm) : src;
    exp_we = 1'b0;
    newv   = old;
    if (f3 == 3'b001 || f3 == 3'b101) begin
      newv = op; exp_we = 1'b1;
    end else if (f3 == 3'b010 || f3 == 3'b110) begin
      newv = old | op; exp_we = (op != 0);
    end else if (f3 == 3'b011 || f3 == 3'b111) begin
      newv = old & ~op; exp_we = (op != 0);
    end
    expv = exp_we ? newv : old;
    poke(addr, old);
    @(negedge clk);
    base = wr_q.size();
    bus.csr_req_valid = 1'b1;
    bus.csr_funct3    = f3;
    bus.csr_addr      = addr;
    bus.csr_src       = src;
    bus.csr_zimm      = zimm;
    lat = 0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) clear_inputs();
      checks++;
      if (bus.csr_write_en !== (exp_we && k == 2)) begin
        errors++;
        $display("FAIL csr_we f3=%0d k=%0d: got %b want %b", f3, k, bus.csr_write_en,
                 exp_we && k == 2);
      end
      if (!bus.csr_write_en && bus.csr_wb_addr !== 12'h0) begin
        errors++;
        $display("FAIL csr_wb_addr_idle: got %h want 000", bus.csr_wb_addr);
      end
      if (bus.csr_done) begin
        lat = k;
      end else if (bus.busy !== 1'b1 || bus.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL csr_busy k=%0d: got busy %b ready %b want 1 0", k, bus.busy,
                 bus.req_ready);
      end
    end
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL csr_latency f3=%0d: got %0d want 3", f3, lat);
    end
    checks++;
    if (bus.csr_result !== (ill ? 32'h0 : old) || bus.csr_illegal !== ill) begin
      errors++;
      $display("FAIL csr_result f3=%0d: got %h ill %b want %h ill %b", f3, bus.csr_result,
               bus.csr_illegal, ill ? 32'h0 : old, ill);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL csr_end_state: got busy %b ready %b want 0 1", bus.busy, bus.req_ready);
    end
    checks++;
    if (regs[addr] !== expv || wr_q.size() != base + (exp_we ? 1 : 0)) begin
      errors++;
      $display("FAIL csr_value f3=%0d: got %h (%0d writes) want %h (%0d writes)", f3, regs[addr],
               wr_q.size() - base, expv, exp_we ? 1 : 0);
    end
  endtask

  task automatic test_trap(input logic [31:0] cause, input logic [31:0] pc,
                           input logic [31:0] mtvec, input logic [31:0] mstatus,
                           input logic all3);
    logic [31:0] exp_st, exp_pc;
    int          lat, base;
    exp_st = trap_status(mstatus);
    exp_pc = trap_target(mtvec, cause);
    poke(MTVEC, mtvec);
    poke(MSTATUS, mstatus);
    @(negedge clk);
    base = wr_q.size();
    bus.trap_req   = 1'b1;
    bus.trap_cause = cause;
    bus.trap_pc    = pc;
    if (all3) begin
      bus.mret_req      = 1'b1;
      bus.csr_req_valid = 1'b1;
      bus.csr_funct3    = 3'b001;
      bus.csr_addr      = 12'h340;
      bus.csr_src       = 32'hDEAD_BEEF;
    end
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) clear_inputs();
      checks++;
      if (bus.csr_write_en !== (k == 1 || k == 2 || k == 4)) begin
        errors++;
        $display("FAIL trap_we k=%0d: got %b", k, bus.csr_write_en);
      end
      if (bus.redirect_valid) begin
        lat = k;
      end else if (bus.busy !== 1'b1 || bus.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL trap_busy k=%0d: got busy %b ready %b want 1 0", k, bus.busy,
                 bus.req_ready);
      end
    end
    checks++;
    if (lat != 6) begin
      errors++;
      $display("FAIL trap_latency: got %0d want 6", lat);
    end
    checks++;
    if (bus.redirect_pc !== exp_pc) begin
      errors++;
      $display("FAIL trap_redirect: got %h want %h", bus.redirect_pc, exp_pc);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1 || bus.csr_done !== 1'b0) begin
      errors++;
      $display("FAIL trap_end_state: got busy %b ready %b done %b want 0 1 0", bus.busy,
               bus.req_ready, bus.csr_done);
    end
    checks++;
    if (wr_q.size() != base + 3) begin
      errors++;
      $display("FAIL trap_write_count: got %0d want 3", wr_q.size() - base);
    end else if (wr_q[base] !== {MEPC, pc & ~32'h3} || wr_q[base+1] !== {MCAUSE, cause} ||
                 wr_q[base+2] !== {MSTATUS, exp_st}) begin
      errors++;
      $display("FAIL trap_writes: got %h %h %h want %h %h %h", wr_q[base], wr_q[base+1],
               wr_q[base+2], {MEPC, pc & ~32'h3}, {MCAUSE, cause}, {MSTATUS, exp_st});
    end
  endtask

  task automatic test_mret(input logic [31:0] mepc, input logic [31:0] mstatus);
    logic [31:0] exp_st;
    int          lat, base;
    exp_st = mret_status(mstatus);
    poke(MEPC, mepc);
    poke(MSTATUS, mstatus);
    @(negedge clk);
    base = wr_q.size();
    bus.mret_req = 1'b1;
    lat = 0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) clear_inputs();
      checks++;
      if (bus.csr_write_en !== (k == 2)) begin
        errors++;
        $display("FAIL mret_we k=%0d: got %b", k, bus.csr_write_en);
      end
      if (bus.redirect_valid) lat = k;
    end
    checks++;
    if (lat != 4 || bus.redirect_pc !== (mepc & ~32'h3)) begin
      errors++;
      $display("FAIL mret_redirect: got lat %0d pc %h want 4 %h", lat, bus.redirect_pc,
               mepc & ~32'h3);
    end
    checks++;
    if (wr_q.size() != base + 1 || regs[MSTATUS] !== exp_st) begin
      errors++;
      $display("FAIL mret_mstatus: got %h (%0d writes) want %h (1 write)", regs[MSTATUS],
               wr_q.size() - base, exp_st);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    poke(MTVEC, 32'h80);
    poke(MSTATUS, 32'h8);
    @(negedge clk);
    base = wr_q.size();
    bus.trap_req   = 1'b1;
    bus.trap_cause = 32'h5;
    bus.trap_pc    = 32'h2000;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) clear_inputs();
    end
    rst = 1'b1;  // now in the mstatus write cycle; reset is sampled at its closing edge
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus.csr_done, bus.busy, bus.redirect_valid, bus.csr_write_en} !== 4'b0 ||
        bus.req_ready !== 1'b1 || bus.redirect_pc !== 32'h0 || bus.csr_wb_addr !== 12'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got done/busy/rv/we=%b ready %b rpc %h wb %h",
               {bus.csr_done, bus.busy, bus.redirect_valid, bus.csr_write_en}, bus.req_ready,
               bus.redirect_pc, bus.csr_wb_addr);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (bus.redirect_valid !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL midreset_quiet k=%0d: got rv %b busy %b", k, bus.redirect_valid,
                 bus.busy);
      end
    end
    checks++;
    if (wr_q.size() != base + 3) begin
      errors++;
      $display("FAIL midreset_writes: got %0d want 3", wr_q.size() - base);
    end
  endtask

  task automatic test_random_csr();
    logic [2:0]  f3;
    logic [31:0] src;
    logic [4:0]  zimm;
    for (int i = 0; i < 30; i++) begin
      f3   = 3'($urandom_range(0, 7));
      src  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      zimm = ($urandom_range(0, 3) == 0) ? 5'h0 : 5'($urandom_range(1, 31));
      test_csr(f3, 12'h340 + 12'($urandom_range(0, 15)), $urandom, src, zimm);
    end
  endtask

  task automatic test_random_trap_mret();
    logic [31:0] mtvec, cause;
    for (int i = 0; i < 8; i++) begin
      mtvec = $urandom;
      if ($urandom_range(0, 1) == 1) mtvec[1:0] = 2'b01;
      cause = $urandom_range(0, 1) ? {1'b1, 31'($urandom_range(0, 63))} : $urandom;
      test_trap(cause, $urandom, mtvec, $urandom, 1'b0);
      test_mret($urandom, $urandom);
    end
  endtask

  initial begin
    poke_en = 1'b0;
    poke_a  = 12'h0;
    poke_d  = 32'h0;
    test_reset();
    test_trap(32'h2, 32'h1002, 32'h80, 32'h8, 1'b0);
    test_csr(3'b010, 12'h340, 32'h0F, 32'hF0, 5'h0);
    test_csr(3'b111, 12'h340, 32'hFF, 32'h0, 5'h3);
    test_csr(3'b010, 12'h340, 32'hFC, 32'h0, 5'h0);
    test_csr(3'b100, 12'h340, 32'hFC, 32'h55, 5'h7);
    test_csr(3'b001, 12'h340, 32'h12, 32'h0, 5'h0);
    test_trap(32'h2, 32'h1002, 32'h80, 32'h8, 1'b1);
    test_mret(32'h1000, 32'h1880);
    test_trap(32'h8000_0007, 32'h3000, 32'h101, 32'h0, 1'b0);
    test_random_csr();
    test_random_trap_mret();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
